// File: rtl/vga_timing_if.sv
// Interface for the video timing outputs of vga_timing_gen.
//   ce           : pixel clock enable, driven by the consumer side
//   hsync/vsync  : sync pulses, polarity set by the generator parameters
//   active       : visible pixel; blanking is its complement
//   x, y         : active-region coordinates, 0 outside the active region
//   line_start, frame_start, vblank_start : one-px_clk strobes
//   frame_cnt    : completed frames, wraps at 2^16
interface vga_timing_if #(
  parameter int unsigned XW = 12,
  parameter int unsigned YW = 11
) ();
  logic          ce;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          blanking;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          vblank_start;
  logic [15:0]   frame_cnt;

  modport master (
    input  ce,
    output hsync, vsync, active, blanking, x, y,
    output line_start, frame_start, vblank_start, frame_cnt
  );

  modport slave (
    output ce,
    input  hsync, vsync, active, blanking, x, y,
    input  line_start, frame_start, vblank_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style video timing generator.
// Ports:
//   px_clk : pixel clock, all logic on the rising edge
//   rst    : asynchronous active-low reset
//   vga    : vga_timing_if master modport (ce in; syncs, active/blanking,
//            coordinates, strobes and frame counter out)
// Per axis the order is active, front porch, sync, back porch. Coordinates
// and strobes are one ce-cycle behind the counters; sync/active/blanking are
// 1+PIPE_DLY ce-cycles behind so they line up with a downstream pixel pipe.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned PIPE_DLY = 0,
  parameter int unsigned XW       = 12,
  parameter int unsigned YW       = 11
) (
  input  logic         px_clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Pipeline stage layout: {hsync, vsync, active}, already polarity-applied.
  localparam logic [2:0] IDLE_STAGE = {~HS_POL, ~VS_POL, 1'b0};

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          line_start_q, frame_start_q, vblank_start_q;
  logic [15:0]   frame_cnt_q;
  logic          started_q;
  logic [2:0]    pipe_q [PIPE_DLY+1];

  logic       act_raw, hs_raw, vs_raw;
  logic       line_hit, frame_hit, vblank_hit;
  logic [2:0] dec_stage;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vga.ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    act_raw    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_raw     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    line_hit   = (h_cnt_q == '0);
    frame_hit  = line_hit && (v_cnt_q == '0);
    vblank_hit = line_hit && (v_cnt_q == V_ACT);
    dec_stage  = {hs_raw ^ ~HS_POL, vs_raw ^ ~VS_POL, act_raw};
  end

  always_ff @(posedge px_clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_cnt_q    <= '0;
      started_q      <= 1'b0;
      for (int unsigned i = 0; i <= PIPE_DLY; i++) begin
        pipe_q[i] <= IDLE_STAGE;
      end
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      // Strobes self-clear on every edge so they last one px_clk even when ce stalls.
      line_start_q   <= vga.ce & line_hit;
      frame_start_q  <= vga.ce & frame_hit;
      vblank_start_q <= vga.ce & vblank_hit;
      if (vga.ce) begin
        x_q       <= act_raw ? XW'(h_cnt_q) : '0;
        y_q       <= act_raw ? YW'(v_cnt_q) : '0;
        pipe_q[0] <= dec_stage;
        for (int unsigned i = 1; i <= PIPE_DLY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
        // The first frame after reset is not a completed frame.
        if (frame_hit) begin
          started_q <= 1'b1;
          if (started_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
      end
    end
  end

  assign vga.hsync        = pipe_q[PIPE_DLY][2];
  assign vga.vsync        = pipe_q[PIPE_DLY][1];
  assign vga.active       = pipe_q[PIPE_DLY][0];
  assign vga.blanking     = ~pipe_q[PIPE_DLY][0];
  assign vga.x            = x_q;
  assign vga.y            = y_q;
  assign vga.line_start   = line_start_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;
  assign vga.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-mode instances (H 8/2/3/3, V 4/1/2/1;
// positive sync, negative sync, PIPE_DLY=3) and one default 1280x1024 instance,
// all sharing clock, reset and ce.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if #(.XW(4),  .YW(3))  vga0 ();
  vga_timing_if #(.XW(4),  .YW(3))  vga1 ();
  vga_timing_if #(.XW(4),  .YW(3))  vga2 ();
  vga_timing_if #(.XW(12), .YW(11)) vga3 ();
  assign vga0.ce = ce;
  assign vga1.ce = ce;
  assign vga2.ce = ce;
  assign vga3.ce = ce;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .XW(4), .YW(3)
  ) u0 (.px_clk(clk), .rst(rst), .vga(vga0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0), .XW(4), .YW(3)
  ) u1 (.px_clk(clk), .rst(rst), .vga(vga1));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3), .XW(4), .YW(3)
  ) u2 (.px_clk(clk), .rst(rst), .vga(vga2));

  vga_timing_gen u3 (.px_clk(clk), .rst(rst), .vga(vga3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Small-mode decode of counter state s (16 px/line, 8 lines/frame).
  function automatic int m_hs(input int s);
    int h = s % 16;
    return (h >= 10 && h <= 12) ? 1 : 0;
  endfunction
  function automatic int m_vs(input int s);
    int v = (s / 16) % 8;
    return (v >= 5 && v <= 6) ? 1 : 0;
  endfunction
  function automatic int m_act(input int s);
    int h = s % 16;
    int v = (s / 16) % 8;
    return (h < 8 && v < 4) ? 1 : 0;
  endfunction

  // n = ce edge count after reset release; expected u0 outputs sampled after it.
  typedef struct {
    int n;
    int hs, vs, act, x, y, ls, fs, vb, fc;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int idx;
    int act_cnt;
    int ls_cnt;

    //          n    hs vs act x  y  ls fs vb fc
    vec[0]  = '{1,   0, 0, 1,  0, 0, 1, 1, 0, 0};
    vec[1]  = '{2,   0, 0, 1,  1, 0, 0, 0, 0, 0};
    vec[2]  = '{8,   0, 0, 1,  7, 0, 0, 0, 0, 0};
    vec[3]  = '{9,   0, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[4]  = '{11,  1, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[5]  = '{13,  1, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[6]  = '{14,  0, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[7]  = '{17,  0, 0, 1,  0, 1, 1, 0, 0, 0};
    vec[8]  = '{20,  0, 0, 1,  3, 1, 0, 0, 0, 0};
    vec[9]  = '{56,  0, 0, 1,  7, 3, 0, 0, 0, 0};
    vec[10] = '{58,  0, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[11] = '{65,  0, 0, 0,  0, 0, 1, 0, 1, 0};
    vec[12] = '{81,  0, 1, 0,  0, 0, 1, 0, 0, 0};
    vec[13] = '{91,  1, 1, 0,  0, 0, 0, 0, 0, 0};
    vec[14] = '{97,  0, 1, 0,  0, 0, 1, 0, 0, 0};
    vec[15] = '{113, 0, 0, 0,  0, 0, 1, 0, 0, 0};
    vec[16] = '{128, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[17] = '{129, 0, 0, 1,  0, 0, 1, 1, 0, 1};
    vec[18] = '{193, 0, 0, 0,  0, 0, 1, 0, 1, 1};
    vec[19] = '{257, 0, 0, 1,  0, 0, 1, 1, 0, 2};
    vec[20] = '{421, 0, 0, 1,  4, 2, 0, 0, 0, 3};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs",    vga0.hsync, 0);
    chk("rst_vs",    vga0.vsync, 0);
    chk("rst_act",   vga0.active, 0);
    chk("rst_blank", vga0.blanking, 1);
    chk("rst_x",     vga0.x, 0);
    chk("rst_y",     vga0.y, 0);
    chk("rst_ls",    vga0.line_start, 0);
    chk("rst_fs",    vga0.frame_start, 0);
    chk("rst_fc",    vga0.frame_cnt, 0);
    chk("rst_neg_hs", vga1.hsync, 1);
    chk("rst_neg_vs", vga1.vsync, 1);
    chk("rst_p3_hs",  vga2.hsync, 0);
    chk("rst_p3_blank", vga2.blanking, 1);
    chk("rst_def_hs", vga3.hsync, 0);

    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b1;

    // Continuous ce: table vectors for u0/u1, model check for the delayed u2
    n = 0;
    idx = 0;
    act_cnt = 0;
    while (n < 421) begin
      step();
      n++;
      if (n <= 128 && vga0.active) act_cnt++;
      if (n == 128) chk("active_per_frame", act_cnt, 32);
      if (n < 4) begin
        chk("p3_hs", vga2.hsync, 0);
        chk("p3_vs", vga2.vsync, 0);
        chk("p3_act", vga2.active, 0);
      end else begin
        chk("p3_hs", vga2.hsync, m_hs(n - 4));
        chk("p3_vs", vga2.vsync, m_vs(n - 4));
        chk("p3_act", vga2.active, m_act(n - 4));
      end
      if (n == 385) chk("fc_after_4th_fs", vga0.frame_cnt, 3);
      if (idx < NV && vec[idx].n == n) begin
        chk($sformatf("v%0d_hs", n), vga0.hsync, vec[idx].hs);
        chk($sformatf("v%0d_vs", n), vga0.vsync, vec[idx].vs);
        chk($sformatf("v%0d_act", n), vga0.active, vec[idx].act);
        chk($sformatf("v%0d_blank", n), vga0.blanking, 1 - vec[idx].act);
        chk($sformatf("v%0d_x", n), vga0.x, vec[idx].x);
        chk($sformatf("v%0d_y", n), vga0.y, vec[idx].y);
        chk($sformatf("v%0d_ls", n), vga0.line_start, vec[idx].ls);
        chk($sformatf("v%0d_fs", n), vga0.frame_start, vec[idx].fs);
        chk($sformatf("v%0d_vb", n), vga0.vblank_start, vec[idx].vb);
        chk($sformatf("v%0d_fc", n), vga0.frame_cnt, vec[idx].fc);
        chk($sformatf("v%0d_neg_hs", n), vga1.hsync, 1 - vec[idx].hs);
        chk($sformatf("v%0d_neg_vs", n), vga1.vsync, 1 - vec[idx].vs);
        chk($sformatf("v%0d_neg_act", n), vga1.active, vec[idx].act);
        chk($sformatf("v%0d_p3_x", n), vga2.x, vec[idx].x);
        chk($sformatf("v%0d_p3_ls", n), vga2.line_start, vec[idx].ls);
        idx++;
      end
    end
    chk("all_vectors_reached", idx, NV);

    // Reset mid-frame: counters sit at h=5, v=2 of the fourth frame
    rst = 1'b0;
    #1;
    chk("mid_rst_hs",    vga0.hsync, 0);
    chk("mid_rst_act",   vga0.active, 0);
    chk("mid_rst_blank", vga0.blanking, 1);
    chk("mid_rst_x",     vga0.x, 0);
    chk("mid_rst_y",     vga0.y, 0);
    chk("mid_rst_fc",    vga0.frame_cnt, 0);
    chk("mid_rst_neg_hs", vga1.hsync, 1);
    chk("mid_rst_neg_vs", vga1.vsync, 1);
    chk("mid_rst_p3_act", vga2.active, 0);
    @(negedge clk);
    rst = 1'b1;

    // Default mode after release (also first-ce behaviour of u0)
    n = 0;
    ls_cnt = 0;
    while (n < 1700) begin
      step();
      n++;
      if (vga3.line_start) ls_cnt++;
      if (vga3.vblank_start) chk("def_no_vblank", vga3.vblank_start, 0);
      case (n)
        1: begin
          chk("rel_fs", vga0.frame_start, 1);
          chk("rel_ls", vga0.line_start, 1);
          chk("rel_x",  vga0.x, 0);
          chk("rel_y",  vga0.y, 0);
          chk("rel_fc", vga0.frame_cnt, 0);
          chk("def_fs1", vga3.frame_start, 1);
        end
        2:    chk("rel_fs_clear", vga0.frame_start, 0);
        1280: begin
          chk("def_act_last", vga3.active, 1);
          chk("def_x_last",   vga3.x, 1279);
        end
        1281: begin
          chk("def_act_off", vga3.active, 0);
          chk("def_blank",   vga3.blanking, 1);
          chk("def_x_off",   vga3.x, 0);
        end
        1328: chk("def_hs_pre",  vga3.hsync, 0);
        1329: chk("def_hs_on",   vga3.hsync, 1);
        1440: chk("def_hs_last", vga3.hsync, 1);
        1441: chk("def_hs_off",  vga3.hsync, 0);
        1688: chk("def_ls_pre",  vga3.line_start, 0);
        1689: begin
          chk("def_ls_line1", vga3.line_start, 1);
          chk("def_y_line1",  vga3.y, 1);
          chk("def_act_line1", vga3.active, 1);
        end
        default: ;
      endcase
    end
    chk("def_ls_count", ls_cnt, 2);

    // ce toggling 1,0,1,0 from a fresh reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ls_cnt = 0;
    for (int c = 1; c <= 64; c++) begin
      ce = (c % 2 == 1) ? 1'b1 : 1'b0;
      step();
      if (vga0.line_start) ls_cnt++;
      case (c)
        1:  begin
          chk("ce_ls1", vga0.line_start, 1);
          chk("ce_fs1", vga0.frame_start, 1);
        end
        2:  begin
          chk("ce_ls1_clear", vga0.line_start, 0);
          chk("ce_fs1_clear", vga0.frame_start, 0);
        end
        3:  chk("ce_x1", vga0.x, 1);
        4:  chk("ce_x1_hold", vga0.x, 1);
        15: chk("ce_x7", vga0.x, 7);
        16: chk("ce_x7_hold", vga0.x, 7);
        17: chk("ce_x_blank", vga0.x, 0);
        32: chk("ce_ls_not_early", vga0.line_start, 0);
        33: begin
          chk("ce_ls2", vga0.line_start, 1);
          chk("ce_y1", vga0.y, 1);
        end
        34: chk("ce_ls2_clear", vga0.line_start, 0);
        default: ;
      endcase
    end
    chk("ce_ls_count", ls_cnt, 2);
    ce = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
